// File: rtl/axi_sram_rd_slave_pkg.sv
// Shared types and constants for the SRAM-backed AXI read slave.
// The optional WRAP burst support is enabled with the AXI_RD_WRAP_EN macro.
package axi_sram_rd_slave_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } burst_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StData,
        StErr
    } rd_slave_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    // Wrap bursts need a power-of-two beat count of at least two.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return len inside {4'd1, 4'd3, 4'd7, 4'd15};
    endfunction

endpackage

// File: rtl/axi_sram_rd_slave_if.sv
// AXI read address and read data channels between interconnect and read slave.
interface axi_sram_rd_slave_if #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [3:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/axi_sram_rd_slave_addr_gen.sv
// Combinational next-word-address for FIXED/INCR/WRAP bursts.
// WRAP windows apply only when AXI_RD_WRAP_EN is defined; otherwise WRAP acts as INCR.
module axi_sram_rd_slave_addr_gen
    import axi_sram_rd_slave_pkg::*;
#(
    parameter int unsigned MEM_AW = 14
) (
    input  logic [MEM_AW-1:0] addr,
    input  logic [3:0]        len,
    input  burst_t            burst,
    output logic [MEM_AW-1:0] next_addr
);

    logic [MEM_AW-1:0] incr_addr;
    assign incr_addr = addr + MEM_AW'(1);

`ifdef AXI_RD_WRAP_EN
    logic [MEM_AW-1:0] wrap_mask;
    logic [MEM_AW-1:0] wrap_addr;
    assign wrap_mask = MEM_AW'(len);
    assign wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = incr_addr;
        case (burst)
            BurstFixed: next_addr = addr;
            BurstIncr:  next_addr = incr_addr;
`ifdef AXI_RD_WRAP_EN
            BurstWrap:  next_addr = wrap_addr;
`else
            BurstWrap:  next_addr = incr_addr;
`endif
            default:    next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_sram_rd_slave.sv
// AXI read slave front end for a single-port synchronous SRAM, one beat in flight.
// Optional WRAP burst support is selected by the AXI_RD_WRAP_EN macro.
module axi_sram_rd_slave
    import axi_sram_rd_slave_pkg::*;
#(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 14
) (
    input  logic                clk,
    input  logic                rst,
    axi_sram_rd_slave_if.slave  bus,
    output logic                SRAM_CS,
    output logic                SRAM_OE,
    output logic [MEM_AW-1:0]   SRAM_A,
    input  logic [DATA_W-1:0]   SRAM_DO
);

    rd_slave_state_t   state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [3:0]        len_q, len_d;
    burst_t            burst_q, burst_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [3:0]        beat_q, beat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [MEM_AW-1:0] next_addr;
    logic              last_beat;
    logic              bad_req;
    logic              unused_araddr;

    assign unused_araddr = ^{bus.ARADDR[ADDR_W-1:MEM_AW+2], bus.ARADDR[1:0]};
    assign last_beat     = (beat_q == len_q);

`ifdef AXI_RD_WRAP_EN
    assign bad_req = (bus.ARSIZE != SIZE_4B) ||
                     ((burst_t'(bus.ARBURST) == BurstWrap) && !wrap_len_ok(bus.ARLEN));
`else
    assign bad_req = (bus.ARSIZE != SIZE_4B);
`endif

    axi_sram_rd_slave_addr_gen #(
        .MEM_AW (MEM_AW)
    ) u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            len_q   <= '0;
            burst_q <= BurstFixed;
            addr_q  <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        len_d       = len_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        rdata_d     = rdata_q;
        bus.ARREADY = 1'b0;
        SRAM_CS     = 1'b0;
        SRAM_OE     = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.ARREADY = 1'b1;
                if (bus.ARVALID) begin
                    id_d    = bus.ARID;
                    len_d   = bus.ARLEN;
                    burst_d = burst_t'(bus.ARBURST);
                    addr_d  = bus.ARADDR[MEM_AW+1:2];
                    beat_d  = '0;
                    state_d = bad_req ? StErr : StFetch;
                end
            end
            StFetch: begin
                SRAM_CS = 1'b1;
                SRAM_OE = 1'b1;
                state_d = StLoad;
            end
            StLoad: begin
                SRAM_CS = 1'b1;
                SRAM_OE = 1'b1;
                rdata_d = SRAM_DO;
                state_d = StData;
            end
            StData: begin
                if (bus.RREADY) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = next_addr;
                        state_d = StFetch;
                    end
                end
            end
            StErr: begin
                if (bus.RREADY) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // R channel is decoded from state and registers only, never from RREADY.
    always_comb begin
        bus.RVALID = (state_q == StData) || (state_q == StErr);
        bus.RID    = bus.RVALID ? id_q : '0;
        bus.RDATA  = (state_q == StData) ? rdata_q : '0;
        bus.RRESP  = (state_q == StErr) ? RESP_SLVERR : RESP_OKAY;
        bus.RLAST  = bus.RVALID && last_beat;
        SRAM_A     = SRAM_CS ? addr_q : '0;
    end

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Scoreboard bench for axi_sram_rd_slave: directed AR requests, monitor checks R beats.
// Define AXI_RD_WRAP_EN for both RTL and bench to exercise wrap bursts.
module tb_axi_sram_rd_slave;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        int          gap;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        sram_cs;
    logic        sram_oe;
    logic [13:0] sram_a;
    logic [31:0] sram_do;
    logic [31:0] mem [0:16383];

    int n_checks;
    int n_errors;
    int cycle;
    int cs_count;
    beat_t exp_q[$];

    axi_sram_rd_slave_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_sram_rd_slave #(
        .ID_W   (8),
        .ADDR_W (32),
        .DATA_W (32),
        .MEM_AW (14)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .SRAM_CS (sram_cs),
        .SRAM_OE (sram_oe),
        .SRAM_A  (sram_a),
        .SRAM_DO (sram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        if (sram_cs && sram_oe) sram_do <= mem[sram_a];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last, input int gap);
        beat_t b;
        b.id = id; b.data = data; b.resp = resp; b.last = last; b.gap = gap;
        exp_q.push_back(b);
    endtask

    // Monitor: latency on RVALID rise, hold under backpressure, contents at handshake.
    logic        prev_rvalid;
    logic        stall_prev;
    logic [43:0] snap;
    int          ref_cycle;

    always @(negedge clk) begin
        if (rst) begin
            prev_rvalid = 1'b0;
            stall_prev  = 1'b0;
        end else begin
            if (sram_cs) cs_count++;
            if (bus.ARVALID && bus.ARREADY) ref_cycle = cycle;
            if (stall_prev)
                check("hold", {bus.RVALID, bus.RLAST, bus.RRESP, bus.RID, bus.RDATA}, snap);
            if (bus.RVALID && !prev_rvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_rvalid: got 1 expected 0");
                end else if (exp_q[0].gap != 0) begin
                    check("latency", 64'(cycle - ref_cycle), 64'(exp_q[0].gap));
                end
            end
            if (bus.RVALID && bus.RREADY) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", bus.RDATA);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("rbeat", {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST},
                          {e.id, e.data, e.resp, e.last});
                end
                ref_cycle = cycle;
            end
            stall_prev  = bus.RVALID && !bus.RREADY;
            snap        = {bus.RVALID, bus.RLAST, bus.RRESP, bus.RID, bus.RDATA};
            prev_rvalid = bus.RVALID;
        end
    end

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
        bus.ARSIZE = size; bus.ARBURST = burst; bus.ARVALID = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.ARREADY) done = 1'b1;
        end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL ar_timeout: got no ARREADY expected ARREADY");
        end
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && bus.ARREADY) done = 1'b1;
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int cs_before;
        bit seen;
        n_checks = 0; n_errors = 0; cycle = 0; cs_count = 0; ref_cycle = 0;
        prev_rvalid = 1'b0; stall_prev = 1'b0; snap = '0; sram_do = '0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[14'h10]   = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) mem[i] = 32'h100 + 32'(i);
        mem[14'h11]   = 32'h1111_2222;
        mem[14'h20]   = 32'hA5A5_0001;
        mem[14'h21]   = 32'h5A5A_0002;
        mem[14'h3FFF] = 32'hCAFE_3FFF;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
        bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out", {bus.ARREADY, bus.RVALID, bus.RLAST, sram_cs, sram_oe},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        // Single read
        push(8'h12, 32'hDEAD_BEEF, 2'b00, 1'b1, 3);
        send_ar(8'h12, 32'h40, 4'd0, 3'b010, 2'b01);
        wait_done("single");
        check("arready_after_single", {31'd0, bus.ARREADY}, 64'd1);

        // INCR burst of four
        for (int i = 0; i < 4; i++) push(8'h21, 32'h100 + 32'(i), 2'b00, i == 3, 3);
        send_ar(8'h21, 32'h0, 4'd3, 3'b010, 2'b01);
        wait_done("incr");

        // Backpressure on first beat of a two-beat burst
        bus.RREADY = 1'b0;
        push(8'h33, 32'hA5A5_0001, 2'b00, 1'b0, 3);
        push(8'h33, 32'h5A5A_0002, 2'b00, 1'b1, 3);
        send_ar(8'h33, 32'h80, 4'd1, 3'b010, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.RVALID) seen = 1'b1;
        end
        check("bp_rvalid_seen", {63'd0, seen}, 64'd1);
        repeat (5) @(posedge clk);
        #1 bus.RREADY = 1'b1;
        wait_done("backpressure");

        // INCR across the top of the SRAM
        push(8'h44, 32'hCAFE_3FFF, 2'b00, 1'b0, 3);
        push(8'h44, 32'h100, 2'b00, 1'b1, 3);
        send_ar(8'h44, 32'hFFFC, 4'd1, 3'b010, 2'b01);
        wait_done("addr_wrap");

        // Unsupported size goes down the error path without touching the SRAM
        cs_before = cs_count;
        for (int i = 0; i < 3; i++) push(8'h55, 32'h0, 2'b10, i == 2, (i == 0) ? 1 : 0);
        send_ar(8'h55, 32'h40, 4'd2, 3'b001, 2'b01);
        wait_done("bad_size");
        check("bad_size_no_cs", 64'(cs_count), 64'(cs_before));

        // FIXED burst rereads the same word
        for (int i = 0; i < 3; i++) push(8'h66, 32'h1111_2222, 2'b00, i == 2, 3);
        send_ar(8'h66, 32'h44, 4'd2, 3'b010, 2'b00);
        wait_done("fixed");

`ifdef AXI_RD_WRAP_EN
        push(8'h77, 32'h106, 2'b00, 1'b0, 3);
        push(8'h77, 32'h107, 2'b00, 1'b0, 3);
        push(8'h77, 32'h104, 2'b00, 1'b0, 3);
        push(8'h77, 32'h105, 2'b00, 1'b1, 3);
        send_ar(8'h77, 32'h18, 4'd3, 3'b010, 2'b10);
        wait_done("wrap");
        for (int i = 0; i < 3; i++) push(8'h78, 32'h0, 2'b10, i == 2, (i == 0) ? 1 : 0);
        send_ar(8'h78, 32'h18, 4'd2, 3'b010, 2'b10);
        wait_done("wrap_badlen");
`else
        for (int i = 0; i < 4; i++) push(8'h77, 32'h106 + 32'(i), 2'b00, i == 3, 3);
        send_ar(8'h77, 32'h18, 4'd3, 3'b010, 2'b10);
        wait_done("wrap_as_incr");
`endif

        // Reset while a beat is waiting in DATA
        bus.RREADY = 1'b0;
        push(8'h88, 32'h100, 2'b00, 1'b0, 3);
        push(8'h88, 32'h101, 2'b00, 1'b1, 3);
        send_ar(8'h88, 32'h0, 4'd1, 3'b010, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.RVALID) seen = 1'b1;
        end
        check("rst_rvalid_seen", {63'd0, seen}, 64'd1);
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("rst_rvalid_drop", {63'd0, bus.RVALID}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.RREADY = 1'b1;
        @(negedge clk);
        check("rst_release", {bus.ARREADY, bus.RVALID, bus.RLAST}, {1'b1, 1'b0, 1'b0});
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
